// File: rtl/pipe_select_subtractor_if.sv
// pipe_select_subtractor_if
// Groups the operand and result handshake of the pipelined carry-select
// subtractor.
//   in_valid/in_ready   : operand handshake (A, B, Bin)
//   out_valid/out_ready : result handshake (D, Bout, OV)
// Modports:
//   master : the environment; drives operands and out_ready
//   slave  : the subtractor; drives in_ready and results
interface pipe_select_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             OV;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, D, Bout, OV
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, D, Bout, OV
  );
endinterface

// File: rtl/pipe_select_subtractor.sv
// pipe_select_subtractor
// Pipelined carry-select subtractor, D = A - B - Bin, one SEG-bit segment
// per stage. Each segment is evaluated for both borrow-in values and the
// registered borrow of the previous stage picks one. Latency is
// STAGES-1 edges after the accepting edge; one result per cycle when the
// consumer keeps out_ready high.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, flushes all in-flight work
//   bus   : slave side of pipe_select_subtractor_if (A, B, Bin, in_valid,
//           in_ready, D, Bout, OV, out_valid, out_ready)
// Parameters: WIDTH (multiple of SEG), SEG. STAGES = WIDTH/SEG is derived.
// Optional macro SUB_SATURATE_EN: on signed overflow the final stage replaces
// D with the signed saturation value chosen by the sign of A. Bout/OV keep
// their unsaturated meaning.
module pipe_select_subtractor #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  pipe_select_subtractor_if.slave bus
);

  localparam int STAGES = WIDTH / SEG;

  if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_param_check
    $error("pipe_select_subtractor: WIDTH must be a positive multiple of SEG");
  end

  logic advance;
  logic out_valid_w;

  for (genvar gi = 0; gi < STAGES; gi++) begin : stg
    localparam int LO = gi * SEG;   // first bit of this stage's segment
    localparam int HI = LO + SEG;   // result bits known after this stage

    // Operand bits still to be consumed, starting at this segment.
    logic              vld_in;
    logic              brw_in;
    logic [WIDTH-LO-1:0] a_in;
    logic [WIDTH-LO-1:0] b_in;

    logic [SEG:0]      sum_b0;   // borrow-in 0 (carry-in 1)
    logic [SEG:0]      sum_b1;   // borrow-in 1 (carry-in 0)
    logic [SEG:0]      sel;
    logic [HI-1:0]     res_cat;

    logic              vld_d, vld_q;
    logic              brw_d, brw_q;
    logic [HI-1:0]     res_d, res_q;

    // Subtraction as A + ~B + carry, with carry = ~borrow.
    always_comb begin
      sum_b0 = {1'b0, a_in[SEG-1:0]} + {1'b0, ~b_in[SEG-1:0]} + {{SEG{1'b0}}, 1'b1};
      sum_b1 = {1'b0, a_in[SEG-1:0]} + {1'b0, ~b_in[SEG-1:0]};
      sel    = brw_in ? sum_b1 : sum_b0;
      vld_d  = vld_in;
      brw_d  = ~sel[SEG];
    end

    if (gi == 0) begin : g_first
      assign vld_in = bus.in_valid;
      assign brw_in = bus.Bin;
      assign a_in   = bus.A;
      assign b_in   = bus.B;
      always_comb res_cat = sel[SEG-1:0];
    end else begin : g_next
      assign vld_in = stg[gi-1].vld_q;
      assign brw_in = stg[gi-1].brw_q;
      assign a_in   = stg[gi-1].g_mid.a_q;
      assign b_in   = stg[gi-1].g_mid.b_q;
      always_comb res_cat = {sel[SEG-1:0], stg[gi-1].res_q};
    end

    if (gi < STAGES - 1) begin : g_mid
      // Carry forward only the segments later stages still need.
      logic [WIDTH-HI-1:0] a_d, a_q;
      logic [WIDTH-HI-1:0] b_d, b_q;

      always_comb begin
        a_d   = a_in[WIDTH-LO-1:SEG];
        b_d   = b_in[WIDTH-LO-1:SEG];
        res_d = res_cat;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      logic cin_msb;
      logic ov_d, ov_q;

      always_comb begin
        // Sum bit = a ^ ~b ^ carry_in, so the carry into the MSB falls out
        // of the result bit without a separate adder.
        cin_msb = res_cat[WIDTH-1] ^ a_in[SEG-1] ^ ~b_in[SEG-1];
        ov_d    = cin_msb ^ sel[SEG];
        res_d   = res_cat;
`ifdef SUB_SATURATE_EN
        if (ov_d) begin
          res_d = a_in[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov_q <= 1'b0;
        end else if (advance) begin
          ov_q <= ov_d;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        brw_q <= 1'b0;
        res_q <= '0;
      end else if (advance) begin
        vld_q <= vld_d;
        brw_q <= brw_d;
        res_q <= res_d;
      end
    end
  end

  // The whole pipe moves in lockstep (bubbles included) unless a valid result
  // is stalled at the output.
  assign out_valid_w   = stg[STAGES-1].vld_q;
  assign advance       = !out_valid_w || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_w;
  // Stale data in an empty output slot is masked.
  assign bus.D         = out_valid_w ? stg[STAGES-1].res_q : '0;
  assign bus.Bout      = out_valid_w & stg[STAGES-1].brw_q;
  assign bus.OV        = out_valid_w & stg[STAGES-1].g_last.ov_q;

endmodule

// File: tb/tb_pipe_select_subtractor.sv
// tb_pipe_select_subtractor
// Directed and random stimulus for pipe_select_subtractor (WIDTH=16, SEG=4).
// Expected results are queued when an operand handshake happens and compared
// when a result handshake happens.
module tb_pipe_select_subtractor;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bout;
    logic        ov;
  } exp_t;

`ifdef SUB_SATURATE_EN
  localparam logic [15:0] OV1_D = 16'h8000;
  localparam logic [15:0] OV2_D = 16'h7FFF;
`else
  localparam logic [15:0] OV1_D = 16'h7FFF;
  localparam logic [15:0] OV2_D = 16'h8000;
`endif

  logic clk;
  logic rst_n;

  pipe_select_subtractor_if #(.WIDTH(16)) bus ();

  pipe_select_subtractor #(.WIDTH(16), .SEG(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t override_exp;
  bit   have_override;
  int   n_assert;
  int   n_fail;
  int   n_out;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    exp_t e;
    logic [16:0] diff;
    diff   = {1'b0, a} - {1'b0, b} - {16'b0, bin};
    e.a    = a;
    e.b    = b;
    e.bin  = bin;
    e.d    = diff[15:0];
    e.bout = diff[16];
    e.ov   = (a[15] ^ b[15]) & (diff[15] ^ a[15]);
`ifdef SUB_SATURATE_EN
    if (e.ov) e.d = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven: scores the handshakes
  // that the next rising edge will complete, then moves to the next falling edge.
  task automatic cycle();
    exp_t e;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_out: observed D=%h with empty scoreboard, expected no output", bus.D);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("D", {16'b0, bus.D}, {16'b0, e.d});
        check("Bout", {31'b0, bus.Bout}, {31'b0, e.bout});
        check("OV", {31'b0, bus.OV}, {31'b0, e.ov});
        n_out++;
        $display("txn A=%h B=%h Bin=%0d -> D=%h Bout=%0d OV=%0d", e.a, e.b, e.bin, bus.D, bus.Bout, bus.OV);
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      if (have_override) begin
        sb.push_back(override_exp);
        have_override = 1'b0;
      end else begin
        sb.push_back(model(bus.A, bus.B, bus.Bin));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic bin,
                          input logic [15:0] ed, input logic eb, input logic eo);
    int lat;
    bus.A         = a;
    bus.B         = b;
    bus.Bin       = bin;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    override_exp  = '{a, b, bin, ed, eb, eo};
    have_override = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 10) begin
      cycle();
      lat++;
    end
    check("latency", lat, 3);
    cycle();
  endtask

  task automatic run_stream(input bit toggle);
    logic [15:0] a_tab [6];
    logic [15:0] b_tab [6];
    logic        bin_tab [6];
    logic [15:0] held_d;
    int sent, cyc, hold, out0;
    bit seen_first, hold_first, acc;
    for (int i = 0; i < 6; i++) begin
      a_tab[i]   = 16'($urandom);
      b_tab[i]   = 16'($urandom);
      bin_tab[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; cyc = 0; hold = 0; out0 = n_out;
    seen_first = toggle; hold_first = 1'b0; held_d = '0;
    bus.out_ready = 1'b1;
    while ((sent < 6 || sb.size() != 0) && cyc < 200) begin
      if (sent < 6) begin
        bus.in_valid = 1'b1;
        bus.A        = a_tab[sent];
        bus.B        = b_tab[sent];
        bus.Bin      = bin_tab[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      if (!seen_first && bus.out_valid) begin
        seen_first = 1'b1;
        hold       = 4;
        hold_first = 1'b1;
        held_d     = bus.D;
      end
      if (hold > 0)    bus.out_ready = 1'b0;
      else if (toggle) bus.out_ready = ~bus.out_ready;
      else             bus.out_ready = 1'b1;
      #1;
      if (hold > 0) begin
        check("hold_in_ready", {31'b0, bus.in_ready}, 0);
        if (!hold_first) begin
          check("hold_d", {16'b0, bus.D}, {16'b0, held_d});
          check("hold_valid", {31'b0, bus.out_valid}, 1);
        end
        hold_first = 1'b0;
        hold--;
      end
      acc = bus.in_valid && bus.in_ready;
      cycle();
      if (acc) sent++;
      cyc++;
    end
    check("stream_pending", (6 - sent) + sb.size(), 0);
    check("stream_count", n_out - out0, 6);
  endtask

  initial begin
    n_assert = 0; n_fail = 0; n_out = 0; have_override = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b1; bus.A = 16'h1111; bus.B = 16'h0001; bus.Bin = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state, with in_valid held high throughout.
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", {31'b0, bus.in_ready}, 1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 0);
    check("rst_D", {16'b0, bus.D}, 0);
    check("rst_Bout", {31'b0, bus.Bout}, 0);
    check("rst_OV", {31'b0, bus.OV}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("idle_after_rst", {31'b0, bus.out_valid}, 0);
      cycle();
    end

    // Directed arithmetic cases.
    send_one(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    send_one(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    send_one(16'h0010, 16'h0010, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    send_one(16'h8000, 16'h0001, 1'b0, OV1_D,    1'b0, 1'b1);
    send_one(16'h7FFF, 16'hFFFF, 1'b0, OV2_D,    1'b1, 1'b1);

    // Streaming with a 4-cycle stall, then with a toggling consumer.
    run_stream(1'b0);
    run_stream(1'b1);

    // Reset while three transactions are in flight.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.A = 16'($urandom); bus.B = 16'($urandom); bus.Bin = 1'($urandom_range(0, 1));
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    cycle();
    check("pre_rst_valid", {31'b0, bus.out_valid}, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, bus.out_valid}, 0);
    check("async_rst_D", {16'b0, bus.D}, 0);
    check("async_rst_in_ready", {31'b0, bus.in_ready}, 1);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("flushed_idle", {31'b0, bus.out_valid}, 0);
      cycle();
    end
    send_one(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_select_subtractor.md
Name: pipe_select_subtractor

Overview:
- Pipelined carry-select subtractor: D = A - B - Bin, computed one SEG-bit segment per pipeline stage.
- Each segment precomputes both borrow-in cases and selects with the registered borrow from the previous stage.
- Has a valid/ready handshake on both sides with full backpressure.
- Sits in the arithmetic datapath as the subtraction counterpart of the team's carry-select adders.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of SEG (elaboration error otherwise).
- SEG, 4, segment width per stage; STAGES = WIDTH/SEG (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands this cycle.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- D  output  WIDTH  difference, modulo 2^WIDTH.
- Bout  output  1  borrow out; 1 iff unsigned A < B + Bin.
- OV  output  1  signed (two's-complement) overflow.

Behaviour:
- Reset: rst_n low clears all stage valid bits and all data registers, asynchronously. Then out_valid=0, D=0, Bout=0, OV=0, in_ready=1. Reset mid-operation discards every in-flight transaction; nothing is emitted after release.
- Arithmetic: computed internally as A + ~B + ~Bin, with carry = ~borrow.
  - Segment k (bits k*SEG+SEG-1 : k*SEG) is computed twice, for borrow-in 0 and 1.
  - The pair is muxed by the borrow from segment k-1. Segment 0 uses Bin.
  - OV = carry into MSB XOR carry out of MSB.
  - Bout = inverted carry out of the MSB.
- Pipeline:
  - Stage k register holds: valid bit, result bits of segments 0..k, borrow out of segment k, and the still-unconsumed A/B segments (k+1..STAGES-1).
  - Stage 0 is computed combinationally from the input ports.
- Advance: advance = !out_valid || out_ready; in_ready = advance.
  - When advance=1, every stage register shifts one place. Bubbles (valid=0) shift too.
  - When advance=0, all registers hold.
- Accept: a transaction is accepted at an edge where in_valid && in_ready.
- Latency: a transaction accepted at edge N drives out_valid/D/Bout/OV after edge N+STAGES-1 (16/4 config: 3 edges after accept).
- Throughput: one result per cycle when out_ready stays high.
- Output stability: while out_valid=1 && out_ready=0, D/Bout/OV hold stable and no input is accepted.
- Ordering: results leave in acceptance order; no loss or duplication.
- Simultaneous accept and output handshake in the same cycle is legal and is the normal streaming case.
- in_valid=0 while advance=1 inserts a bubble; out_valid drops for that slot.
- STAGES=1: single register stage, latency 0 extra edges after accept.
- Data registers of invalid stages may hold stale values, but outputs D/Bout/OV are forced to 0 when out_valid=0.

Optional Feature:
- Macro: SUB_SATURATE_EN.
- Defined: when OV=1 the last stage replaces D with signed saturation.
  - A MSB=0 → 0x7FFF.
  - A MSB=1 → 0x8000.
  - (In general: WIDTH-1 ones / MSB-only.)
  - Bout and OV remain the unsaturated values; latency unchanged.
- Undefined: D is always the wrap-around modulo result; no saturation logic is present.

Test Plan (WIDTH=16, SEG=4):
1. rst_n=0 with in_valid=1 → in_ready=1, out_valid=0, D=0x0000, Bout=0, OV=0; no output after release until a new accept.
2. A=0x1234, B=0x0234, Bin=0, out_ready=1 → 3 edges after accept: out_valid=1, D=0x1000, Bout=0, OV=0.
3. A=0x0000, B=0x0001, Bin=0 → D=0xFFFF, Bout=1, OV=0 (borrow crosses all 4 segments). A=0x0010, B=0x0010, Bin=1 → D=0xFFFF, Bout=1, OV=0.
4. Overflow cases:
   - A=0x8000, B=0x0001 → D=0x7FFF, Bout=0, OV=1; with SUB_SATURATE_EN, D=0x8000.
   - A=0x7FFF, B=0xFFFF → D=0x8000, Bout=1, OV=1; with SUB_SATURATE_EN, D=0x7FFF.
5. Stream 6 random transactions back-to-back; hold out_ready=0 for 4 cycles after the first result.
   - in_ready=0 during the hold; D stays stable.
   - All 6 results arrive in order and match the model; no duplicates.
   - Then toggle out_ready each cycle and check the same.
6. Accept 3 transactions, assert rst_n=0 for one cycle while they are in flight → out_valid=0 immediately; no results emerge after release; the next transaction A=0x0005, B=0x0003 → D=0x0002.
